// File: rtl/fas_pkg.sv
// FAS frequency analyzer shared types and sizes.
// Bin count, sample widths, scan state and complex sample layout.
package fas_pkg;

  localparam int NPT   = 16;
  localparam int DW    = 16;
  localparam int MAGW  = 2*DW+1;
  localparam int FREQW = $clog2(NPT);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fas_mag_sq.sv
// FAS magnitude-squared unit.
// re^2 + im^2 of one signed sample, unsigned and one bit wider.
module fas_mag_sq
  import fas_pkg::*;
(
  input  logic signed [DW-1:0] re,
  input  logic signed [DW-1:0] im,
  output logic [MAGW-1:0]      mag
);

  logic signed [2*DW-1:0] re_x;
  logic signed [2*DW-1:0] im_x;
  logic signed [2*DW-1:0] re2;
  logic signed [2*DW-1:0] im2;

  // Squares are never negative and -128.0^2 still fits in 2*DW bits.
  always_comb begin
    re_x = $signed({{DW{re[DW-1]}}, re});
    im_x = $signed({{DW{im[DW-1]}}, im});
    re2  = re_x * re_x;
    im2  = im_x * im_x;
    mag  = {1'b0, re2} + {1'b0, im2};
  end

endmodule

// File: rtl/fas_freq_analyzer.sv
// FAS frequency analyzer: serial peak-bin search over one FFT frame.
// One bin per cycle; done/freq/mag_max one cycle after the last bin.
module fas_freq_analyzer
  import fas_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fft_valid,
  input  logic [2*DW-1:0]   fft_d0,
  input  logic [2*DW-1:0]   fft_d1,
  input  logic [2*DW-1:0]   fft_d2,
  input  logic [2*DW-1:0]   fft_d3,
  input  logic [2*DW-1:0]   fft_d4,
  input  logic [2*DW-1:0]   fft_d5,
  input  logic [2*DW-1:0]   fft_d6,
  input  logic [2*DW-1:0]   fft_d7,
  input  logic [2*DW-1:0]   fft_d8,
  input  logic [2*DW-1:0]   fft_d9,
  input  logic [2*DW-1:0]   fft_d10,
  input  logic [2*DW-1:0]   fft_d11,
  input  logic [2*DW-1:0]   fft_d12,
  input  logic [2*DW-1:0]   fft_d13,
  input  logic [2*DW-1:0]   fft_d14,
  input  logic [2*DW-1:0]   fft_d15,
  output logic              done,
  output logic [FREQW-1:0]  freq,
  output logic [MAGW-1:0]   mag_max,
  output logic              busy,
  output logic              overrun
);

  localparam logic [FREQW-1:0] LAST = FREQW'(NPT-1);

  state_t           state_q;
  state_t           state_d;
  logic [FREQW-1:0] idx;
  cplx_t            buf_q [NPT];
  logic [2*DW-1:0]  din   [NPT];
  cplx_t            cur;
  logic [MAGW-1:0]  m;
  logic [MAGW-1:0]  run_max;
  logic [FREQW-1:0] run_idx;
  logic [MAGW-1:0]  nxt_max;
  logic [FREQW-1:0] nxt_idx;
  logic             pend_v;
  logic [MAGW-1:0]  pend_max;
  logic [FREQW-1:0] pend_idx;
  logic             last;
  logic             accept;
  logic             reject;

  assign din = '{fft_d0,  fft_d1,  fft_d2,  fft_d3,
                 fft_d4,  fft_d5,  fft_d6,  fft_d7,
                 fft_d8,  fft_d9,  fft_d10, fft_d11,
                 fft_d12, fft_d13, fft_d14, fft_d15};

  assign cur = buf_q[idx];

  fas_mag_sq u_mag (
    .re  (cur.re),
    .im  (cur.im),
    .mag (m)
  );

  // Running-max update; strict compare keeps the lowest index on ties.
  always_comb begin
    last   = (state_q == SCAN) && (idx == LAST);
    accept = fft_valid && ((state_q == IDLE) || last);
    reject = fft_valid && (state_q == SCAN) && !last;
    if ((idx == '0) || (m > run_max)) begin
      nxt_max = m;
      nxt_idx = idx;
    end else begin
      nxt_max = run_max;
      nxt_idx = run_idx;
    end
  end

  // Next state: a new frame may chain straight onto the last bin.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SCAN;
      SCAN:    if (last && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Frame buffer, scan index, running max and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPT; i++) buf_q[i] <= '0;
      idx      <= '0;
      run_max  <= '0;
      run_idx  <= '0;
      pend_v   <= 1'b0;
      pend_max <= '0;
      pend_idx <= '0;
      done     <= 1'b0;
      freq     <= '0;
      mag_max  <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= reject;
      done    <= pend_v;
      pend_v  <= last;
      if (last) begin
        pend_max <= nxt_max;
        pend_idx <= nxt_idx;
      end
      if (pend_v) begin
        freq    <= pend_idx;
        mag_max <= pend_max;
      end
      if (state_q == SCAN) begin
        run_max <= nxt_max;
        run_idx <= nxt_idx;
        idx     <= idx + 1'b1;
      end
      if (accept) begin
        for (int i = 0; i < NPT; i++) buf_q[i] <= din[i];
        idx     <= '0;
        run_max <= '0;
        run_idx <= '0;
      end
    end
  end

  assign busy = (state_q == SCAN);

endmodule

// File: tb/tb_fas_freq_analyzer.sv
// Bench for fas_freq_analyzer.
// Vector table plus scoreboard of expected done results.
module tb_fas_freq_analyzer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fft_valid = 1'b0;
  logic [31:0] fd [16];
  logic        done;
  logic [3:0]  freq;
  logic [32:0] mag_max;
  logic        busy;
  logic        overrun;

  typedef struct {
    logic [15:0][31:0] d;
    int                f;
    logic [32:0]       m;
  } vec_t;

  typedef struct {
    int          f;
    logic [32:0] m;
    int          t;
  } exp_t;

  exp_t sb[$];
  vec_t vt[7];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ovr_cnt = 0;

  always #5 clk = ~clk;

  fas_freq_analyzer dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fd[0]),   .fft_d1(fd[1]),   .fft_d2(fd[2]),
    .fft_d3(fd[3]),   .fft_d4(fd[4]),   .fft_d5(fd[5]),
    .fft_d6(fd[6]),   .fft_d7(fd[7]),   .fft_d8(fd[8]),
    .fft_d9(fd[9]),   .fft_d10(fd[10]), .fft_d11(fd[11]),
    .fft_d12(fd[12]), .fft_d13(fd[13]), .fft_d14(fd[14]),
    .fft_d15(fd[15]),
    .done(done), .freq(freq), .mag_max(mag_max),
    .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (overrun) ovr_cnt++;
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done cyc=%0d freq=%0d want=none",
                 cyc, freq);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("freq", 64'(freq), 64'(e.f));
        chk("mag_max", 64'(mag_max), 64'(e.m));
        chk("latency", 64'(cyc - e.t), 64'd17);
      end
    end
  endtask

  task automatic send(input logic [15:0][31:0] d, input bit acc,
                      input int f, input logic [32:0] m);
    exp_t e;
    for (int i = 0; i < 16; i++) fd[i] = d[i];
    fft_valid = 1'b1;
    if (acc) begin
      e.f = f;
      e.m = m;
      e.t = cyc + 1;
      sb.push_back(e);
    end
    tick();
    fft_valid = 1'b0;
    for (int i = 0; i < 16; i++) fd[i] = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
    sb.delete();
    tick();
    tick();
  endtask

  task automatic model(input logic [15:0][31:0] d, output int f,
                       output logic [32:0] m);
    longint best;
    longint r;
    longint q;
    longint mk;
    best = 0;
    f = 0;
    for (int k = 0; k < 16; k++) begin
      r  = longint'($signed(d[k][31:16]));
      q  = longint'($signed(d[k][15:0]));
      mk = r*r + q*q;
      if (k == 0 || mk > best) begin
        best = mk;
        f = k;
      end
    end
    m = 33'(best);
  endtask

  initial begin
    logic [15:0][31:0] fa;
    logic [15:0][31:0] fb;
    logic [15:0]       pool [6];
    int                t0;
    int                rf;
    logic [32:0]       rm;
    bit                allhi;

    for (int i = 0; i < 16; i++) fd[i] = '0;
    pool = '{16'h8000, 16'h7FFF, 16'h0100, 16'hFF00, 16'h0000, 16'h0010};

    for (int i = 0; i < 7; i++) vt[i].d = '0;
    vt[0].d[1]  = {16'h0100, 16'h0000};
    vt[0].f = 1;  vt[0].m = 33'h0_0001_0000;
    vt[1].d[15] = {16'h8000, 16'h0000};
    vt[1].d[1]  = {16'h7FFF, 16'h7FFF};
    vt[1].f = 1;  vt[1].m = 33'h0_7FFE_0002;
    vt[2].d[15] = {16'h8000, 16'h0000};
    vt[2].f = 15; vt[2].m = 33'h0_4000_0000;
    vt[3].d[3]  = {16'h0010, 16'hFFF0};
    vt[3].d[9]  = {16'h0010, 16'hFFF0};
    vt[3].f = 3;  vt[3].m = 33'h0_0000_0200;
    vt[4].f = 0;  vt[4].m = 33'h0;
    vt[5].d[2]  = {16'h7FFF, 16'h7FFF};
    vt[5].d[5]  = {16'h8000, 16'h8000};
    vt[5].f = 5;  vt[5].m = 33'h0_8000_0000;
    vt[6].d[0]  = {16'hFF00, 16'h0100};
    vt[6].d[8]  = {16'h0100, 16'hFF00};
    vt[6].f = 0;  vt[6].m = 33'h0_0002_0000;

    // reset state
    tick();
    tick();
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_freq", 64'(freq), 64'd0);
    chk("rst_mag", 64'(mag_max), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    rst = 1'b0;
    tick();

    // table vectors
    for (int v = 0; v < 7; v++) begin
      send(vt[v].d, 1'b1, vt[v].f, vt[v].m);
      chk("busy_start", 64'(busy), 64'd1);
      drain();
      chk("busy_idle", 64'(busy), 64'd0);
    end

    // random frames against the model
    for (int r = 0; r < 6; r++) begin
      fa = '0;
      for (int k = 0; k < 16; k++)
        fa[k] = {pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)]};
      model(fa, rf, rm);
      send(fa, 1'b1, rf, rm);
      drain();
    end
    chk("no_overrun_table", 64'(ovr_cnt), 64'd0);

    // back-to-back frames
    fa = '0;
    fa[2]  = {16'h0200, 16'h0000};
    fa[14] = {16'h0100, 16'h0100};
    fb = '0;
    fb[2]  = {16'h0100, 16'h0000};
    fb[14] = {16'h0300, 16'h0100};
    ovr_cnt = 0;
    send(fa, 1'b1, 2, 33'h0_0004_0000);
    t0 = cyc;
    allhi = busy;
    for (int i = 0; i < 15; i++) begin
      tick();
      allhi = allhi & busy;
    end
    send(fb, 1'b1, 14, 33'h0_000A_0000);
    allhi = allhi & busy;
    while (cyc < t0 + 31) begin
      tick();
      allhi = allhi & busy;
    end
    chk("busy_b2b", 64'(allhi), 64'd1);
    drain();
    chk("b2b_overrun", 64'(ovr_cnt), 64'd0);

    // overrun: second frame mid-scan is dropped
    ovr_cnt = 0;
    send(fa, 1'b1, 2, 33'h0_0004_0000);
    for (int i = 0; i < 4; i++) tick();
    send(fb, 1'b0, 0, 33'h0);
    chk("overrun_pulse", 64'(overrun), 64'd1);
    tick();
    chk("overrun_clear", 64'(overrun), 64'd0);
    drain();
    for (int i = 0; i < 20; i++) tick();
    chk("overrun_count", 64'(ovr_cnt), 64'd1);

    // reset mid-scan
    send(fb, 1'b1, 14, 33'h0_000A_0000);
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_freq", 64'(freq), 64'd0);
    chk("mid_rst_mag", 64'(mag_max), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_overrun", 64'(overrun), 64'd0);
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    chk("post_rst_busy", 64'(busy), 64'd0);
    send(vt[0].d, 1'b1, vt[0].f, vt[0].m);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
